ltl_report_buffer: RTL and testbench

LTL_REPORT_BUFFER -- requirements
Module: ltl_report_buffer

---
 rtl/ltl_report_pkg.sv | 13 +
 rtl/ltl_report_fifo.sv | 55 +++++
 rtl/ltl_report_buffer.sv | 82 ++++++++
 tb/tb_ltl_report_buffer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ltl_report_pkg.sv
// Shared constants and the report FIFO entry layout for the LTL report buffer.
package ltl_report_pkg;

    localparam int NREP_DEF  = 4;
    localparam int OFF_W_DEF = 16;
    localparam int DEPTH_DEF = 8;

    typedef struct packed {
        logic [OFF_W_DEF-1:0] offset;
        logic [NREP_DEF-1:0]  report;
    } report_entry_t;

endpackage

// File: rtl/ltl_report_fifo.sv
// Synchronous queue of report entries; the head is read straight from registered storage.
module ltl_report_fifo
    import ltl_report_pkg::*;
#(
    parameter type entry_t = report_entry_t,
    parameter int  DEPTH   = DEPTH_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot the push writes into.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // Storage is cleared so the head reads zero until the first push.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ltl_report_buffer.sv
// Tags active automaton reports with the symbol offset and queues them, tracking dropped reports.
module ltl_report_buffer
    import ltl_report_pkg::*;
#(
    parameter int NREP  = NREP_DEF,
    parameter int OFF_W = OFF_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [NREP-1:0]  report_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OFF_W-1:0] out_offset,
    output logic [NREP-1:0]  out_report,
    output logic             overflow,
    output logic [7:0]       drop_count,
    input  logic             clear_ovf
);

    typedef struct packed {
        logic [OFF_W-1:0] offset;
        logic [NREP-1:0]  report;
    } entry_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [OFF_W-1:0] offset_cnt;
    logic             push_req;
    logic             pop;
    logic             full;
    logic             empty;
    logic             drop;
    entry_t           push_entry;
    entry_t           head;

    assign push_req   = run && (report_in != '0);
    assign pop        = out_valid && out_ready;
    assign drop       = push_req && full && !pop;
    assign push_entry = '{offset: offset_cnt, report: report_in};

    assign out_valid  = !empty;
    assign out_offset = head.offset;
    assign out_report = head.report;

    ltl_report_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) offset_cnt <= '0;
        else if (run) offset_cnt <= offset_cnt + 1'b1;
    end

    // A drop in the same cycle as clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= clear_ovf ? 8'd1 : sat_inc(drop_count);
        end else if (clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end
    end

endmodule

// File: tb/tb_ltl_report_buffer.sv
// Directed-vector bench for ltl_report_buffer with default parameters.
module tb_ltl_report_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [3:0]  report_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_offset;
    logic [3:0]  out_report;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clear_ovf;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ltl_report_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .report_in  (report_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_offset (out_offset),
        .out_report (out_report),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clear_ovf  (clear_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; report_in = '0; out_ready = 1'b0; clear_ovf = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; report_in = 4'b1111; out_ready = 1'b0; clear_ovf = 1'b0;
        step();
        reset = 1'b0; run = 1'b0; report_in = '0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", overflow); end
        vectors++; if (drop_count !== 8'd0) begin miscompares++; $display("FAIL reset_drops got %0d want 0", drop_count); end
        vectors++; if (out_offset !== 16'd0) begin miscompares++; $display("FAIL reset_offset got %0d want 0", out_offset); end
        vectors++; if (out_report !== 4'd0) begin miscompares++; $display("FAIL reset_report got %b want 0000", out_report); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1; run = 1'b1; report_in = 4'b0000;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_nopush got %b want 0", out_valid); end
        report_in = 4'b0100;
        step();
        report_in = 4'b0000;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", out_valid); end
        vectors++; if (out_offset !== 16'd1) begin miscompares++; $display("FAIL single_offset got %0d want 1", out_offset); end
        vectors++; if (out_report !== 4'b0100) begin miscompares++; $display("FAIL single_report got %b want 0100", out_report); end
        step();
        run = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_popped got %b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0; run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            report_in = 4'(i + 1);
            step();
        end
        run = 1'b0; report_in = '0;
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b want 1", overflow); end
        vectors++; if (drop_count !== 8'd1) begin miscompares++; $display("FAIL ovf_drops got %0d want 1", drop_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_offset !== 16'(i) || out_report !== 4'(i + 1)) begin
                miscompares++;
                $display("FAIL ovf_drain[%0d] got v=%b off=%0d rep=%b want v=1 off=%0d rep=%b",
                         i, out_valid, out_offset, out_report, i, 4'(i + 1));
            end
            step();
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty got %b want 0", out_valid); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        out_ready = 1'b0; run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            report_in = 4'(i + 1);
            step();
        end
        out_ready = 1'b1; report_in = 4'b1001;
        step();
        run = 1'b0; report_in = '0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fullpp_ovf got %b want 0", overflow); end
        vectors++; if (drop_count !== 8'd0) begin miscompares++; $display("FAIL fullpp_drops got %0d want 0", drop_count); end
        for (int i = 1; i <= 8; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_offset !== 16'(i) || out_report !== 4'(i + 1)) begin
                miscompares++;
                $display("FAIL fullpp_drain[%0d] got v=%b off=%0d rep=%b want v=1 off=%0d rep=%b",
                         i, out_valid, out_offset, out_report, i, 4'(i + 1));
            end
            step();
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fullpp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_clear();
        do_reset();
        out_ready = 1'b0; run = 1'b1; report_in = 4'b0011;
        for (int i = 0; i < 10; i++) step();
        vectors++; if (drop_count !== 8'd2) begin miscompares++; $display("FAIL clr_pre got %0d want 2", drop_count); end
        clear_ovf = 1'b1;
        step();
        run = 1'b0;
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL clr_drop_ovf got %b want 1", overflow); end
        vectors++; if (drop_count !== 8'd1) begin miscompares++; $display("FAIL clr_drop_cnt got %0d want 1", drop_count); end
        step();
        clear_ovf = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL clr_ovf got %b want 0", overflow); end
        vectors++; if (drop_count !== 8'd0) begin miscompares++; $display("FAIL clr_cnt got %0d want 0", drop_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0; run = 1'b1; report_in = 4'b1010;
        for (int i = 0; i < 3; i++) step();
        run = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_queued got %b want 1", out_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_flushed got %b want 0", out_valid); end
        vectors++; if (out_offset !== 16'd0) begin miscompares++; $display("FAIL mid_zero_off got %0d want 0", out_offset); end
        run = 1'b0; report_in = 4'b1111;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_ignored got %b want 0", out_valid); end
        run = 1'b1; report_in = 4'b0010;
        step();
        run = 1'b0; report_in = '0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_next_valid got %b want 1", out_valid); end
        vectors++; if (out_offset !== 16'd0) begin miscompares++; $display("FAIL mid_next_off got %0d want 0", out_offset); end
        vectors++; if (out_report !== 4'b0010) begin miscompares++; $display("FAIL mid_next_rep got %b want 0010", out_report); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_off [3];
        exp_off[0] = 16'd65534; exp_off[1] = 16'd65535; exp_off[2] = 16'd0;
        do_reset();
        out_ready = 1'b0; run = 1'b1; report_in = '0;
        for (int i = 0; i < 65534; i++) step();
        for (int i = 0; i < 3; i++) begin
            report_in = 4'(i + 1);
            step();
        end
        run = 1'b0; report_in = '0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_offset !== exp_off[i] || out_report !== 4'(i + 1)) begin
                miscompares++;
                $display("FAIL wrap[%0d] got v=%b off=%0d rep=%b want v=1 off=%0d rep=%b",
                         i, out_valid, out_offset, out_report, exp_off[i], 4'(i + 1));
            end
            step();
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_empty got %b want 0", out_valid); end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; report_in = '0; out_ready = 1'b0; clear_ovf = 1'b0;
        #1;
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
